// File: rtl/lbm_step_scheduler.sv
// lbm_step_scheduler
//   Sequences lattice-Boltzmann timesteps over an NX x NY grid held in two
//   RAM banks: a streaming pass (read current bank, write next bank after the
//   RAM read latency), a collide pass (handshake each cell with the collider),
//   then a bank swap. It repeats for the requested number of steps.
//
// Ports
//   clk            single clock
//   rst            asynchronous active-low reset
//   en             global run enable; low stalls new issue
//   start          single-cycle run request (honoured only in idle with en=1)
//   step           timesteps to run, latched on an accepted start
//   collider_ready collider accepts the offered cell this cycle
//   rd_addr/rd_en  streaming read to current-bank RAMs (rd_addr = y*NX + x)
//   wr_addr/wr_en  streaming write to next-bank RAMs (read delayed RD_LAT)
//   x, y           coordinates of rd_addr
//   col_valid      cell at rd_addr offered to the collider
//   phase          00 idle, 01 stream, 10 collide, 11 swap/done
//   bank_sel       which RAM set is current
//   steps_done     completed timesteps; busy; done (one-cycle pulse)
module lbm_step_scheduler #(
  parameter  int unsigned NX            = 50,
  parameter  int unsigned NY            = 50,
  parameter  int unsigned RD_LAT        = 1,
  localparam int unsigned DEPTH         = NX * NY,
  localparam int unsigned ADDRESS_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic [31:0]              step,
  input  logic                     collider_ready,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic                     wr_en,
  output logic [7:0]               x,
  output logic [7:0]               y,
  output logic                     col_valid,
  output logic [1:0]               phase,
  output logic                     bank_sel,
  output logic [31:0]              steps_done,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STREAM  = 3'd1;
  localparam logic [2:0] S_COLLIDE = 3'd2;
  localparam logic [2:0] S_SWAP    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cell_q, cell_d;
  logic [7:0]               x_q, x_d;
  logic [7:0]               y_q, y_d;
  logic                     draining_q, draining_d;
  logic [DW-1:0]            drain_q, drain_d;
  logic [31:0]              step_q, step_d;
  logic [31:0]              steps_done_q, steps_done_d;
  logic                     bank_q, bank_d;

  logic [RD_LAT-1:0]        vld_q;
  logic [ADDRESS_WIDTH-1:0] addr_q [RD_LAT];

  logic issue;
  logic offer;
  logic pos_adv;
  logic pos_clr;
  logic last_cell;

  assign last_cell = (cell_q == ADDRESS_WIDTH'(DEPTH - 1));

  always_comb begin
    state_d      = state_q;
    draining_d   = draining_q;
    drain_d      = drain_q;
    step_d       = step_q;
    steps_done_d = steps_done_q;
    bank_d       = bank_q;
    issue        = 1'b0;
    offer        = 1'b0;
    pos_adv      = 1'b0;
    pos_clr      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && en) begin
          step_d       = step;
          steps_done_d = '0;
          draining_d   = 1'b0;
          drain_d      = '0;
          pos_clr      = 1'b1;
          state_d      = (step == 32'd0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        // The grid position is cleared as soon as the last cell issues, so
        // the drain cycles already present cell 0 for the collide pass.
        if (draining_q) begin
          if (drain_q == DW'(RD_LAT - 1)) begin
            draining_d = 1'b0;
            drain_d    = '0;
            state_d    = S_COLLIDE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end else if (en) begin
          issue = 1'b1;
          if (last_cell) begin
            draining_d = 1'b1;
            drain_d    = '0;
            pos_clr    = 1'b1;
          end else begin
            pos_adv = 1'b1;
          end
        end
      end
      S_COLLIDE: begin
        offer = en;
        if (en && collider_ready) begin
          if (last_cell) begin
            pos_clr = 1'b1;
            state_d = S_SWAP;
          end else begin
            pos_adv = 1'b1;
          end
        end
      end
      S_SWAP: begin
        bank_d       = ~bank_q;
        steps_done_d = steps_done_q + 32'd1;
        state_d      = (steps_done_q + 32'd1 == step_q) ? S_DONE : S_STREAM;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cell_d = cell_q;
    x_d    = x_q;
    y_d    = y_q;
    if (pos_clr) begin
      cell_d = '0;
      x_d    = '0;
      y_d    = '0;
    end else if (pos_adv) begin
      cell_d = cell_q + 1'b1;
      if (x_q == 8'(NX - 1)) begin
        x_d = '0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cell_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      draining_q   <= 1'b0;
      drain_q      <= '0;
      step_q       <= '0;
      steps_done_q <= '0;
      bank_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cell_q       <= cell_d;
      x_q          <= x_d;
      y_q          <= y_d;
      draining_q   <= draining_d;
      drain_q      <= drain_d;
      step_q       <= step_d;
      steps_done_q <= steps_done_d;
      bank_q       <= bank_d;
    end
  end

  // Read-to-write delay line; it shifts regardless of en so that reads
  // already issued always retire as writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= issue;
      addr_q[0] <= cell_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  always_comb begin
    case (state_q)
      S_STREAM:       phase = 2'b01;
      S_COLLIDE:      phase = 2'b10;
      S_SWAP, S_DONE: phase = 2'b11;
      default:        phase = 2'b00;
    endcase
  end

  assign rd_addr    = cell_q;
  assign rd_en      = issue;
  assign wr_en      = vld_q[RD_LAT-1];
  assign wr_addr    = addr_q[RD_LAT-1];
  assign x          = x_q;
  assign y          = y_q;
  assign col_valid  = offer;
  assign bank_sel   = bank_q;
  assign steps_done = steps_done_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_lbm_step_scheduler.sv
// Testbench for lbm_step_scheduler: builds an expected per-cycle schedule
// for each run from the stimulus it generates, then drives the DUT and
// compares strobes, addresses, phase, timing and final counters.
module tb_lbm_step_scheduler;

  localparam int NX     = 50;
  localparam int NY     = 50;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = NX * NY;
  localparam int AW     = $clog2(DEPTH);
  localparam int MAXC   = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   step = '0;
  logic          collider_ready = 1'b0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_en, wr_en, col_valid, bank_sel, busy, done;
  logic [7:0]    x, y;
  logic [1:0]    phase;
  logic [31:0]   steps_done;

  lbm_step_scheduler #(.NX(NX), .NY(NY), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .step(step),
    .collider_ready(collider_ready), .rd_addr(rd_addr), .rd_en(rd_en),
    .wr_addr(wr_addr), .wr_en(wr_en), .x(x), .y(y), .col_valid(col_valid),
    .phase(phase), .bank_sel(bank_sel), .steps_done(steps_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected schedule, indexed by cycle number after the start cycle (0).
  logic [1:0] e_ph   [MAXC];
  bit         e_rd   [MAXC];
  bit         e_cv   [MAXC];
  int         e_addr [MAXC];
  bit         en_a   [MAXC];
  bit         rdy_a  [MAXC];
  int         done_c;
  int         done_at;
  int         last_coll;
  bit         exp_bank = 1'b0;

  // en_mode: 0 always on, 1 random ~90%, 2 ten-cycle stall when cell 1000 is due
  // rdy_mode: 0 always ready, 1 ready on odd cycles, 2 random ~70%
  task automatic plan(input int nsteps, input int en_mode, input int rdy_mode);
    int c = 1;
    int issued, acc, stall_left;
    bit stalled = 1'b0;
    stall_left = 0;
    for (int i = 0; i < MAXC; i++) begin
      e_ph[i] = 2'b00; e_rd[i] = 1'b0; e_cv[i] = 1'b0; e_addr[i] = 0;
      en_a[i] = 1'b1; rdy_a[i] = 1'b1;
    end
    for (int s = 0; s < nsteps; s++) begin
      issued = 0;
      while (issued < DEPTH) begin
        if (en_mode == 1) en_a[c] = ($urandom_range(0, 9) != 0);
        else if (en_mode == 2) begin
          if (issued == 1000 && !stalled) begin stalled = 1'b1; stall_left = 10; end
          en_a[c] = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        e_ph[c] = 2'b01;
        if (en_a[c]) begin e_rd[c] = 1'b1; e_addr[c] = issued; issued++; end
        c++;
      end
      for (int d = 0; d < RD_LAT; d++) begin
        if (en_mode == 1) en_a[c] = ($urandom_range(0, 9) != 0);
        e_ph[c] = 2'b01;
        c++;
      end
      acc = 0;
      while (acc < DEPTH) begin
        if (en_mode == 1) en_a[c] = ($urandom_range(0, 9) != 0);
        if (rdy_mode == 1) rdy_a[c] = c[0];
        else if (rdy_mode == 2) rdy_a[c] = ($urandom_range(0, 9) < 7);
        e_ph[c] = 2'b10;
        e_cv[c] = en_a[c];
        e_addr[c] = acc;
        if (en_a[c] && rdy_a[c]) acc++;
        c++;
      end
      e_ph[c] = 2'b11;
      c++;
    end
    e_ph[c] = 2'b11;
    done_c = c;
  endtask

  task automatic run(input int nsteps, input int en_mode, input int rdy_mode,
                     input int abort_at, input bit poke_start);
    int ph_err = 0, rd_err = 0, wr_err = 0, cv_err = 0, xy_err = 0, busy_err = 0;
    int done_cnt = 0, wr_cnt = 0, wr_next = 0, order_err = 0, acc_cnt = 0, coll = 0;
    int ce;
    bit we;
    plan(nsteps, en_mode, rdy_mode);
    done_at = -1;
    @(posedge clk); #1;
    start = 1'b1; en = 1'b1; step = nsteps; collider_ready = 1'b1;
    #1;
    check("start_cycle_phase", phase, 2'b00);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      start = poke_start && (c < done_c) && ($urandom_range(0, 19) == 0);
      step = $urandom;
      en = en_a[c];
      collider_ready = rdy_a[c];
      #1;
      if (phase !== e_ph[c]) ph_err++;
      if (rd_en !== e_rd[c] || (e_rd[c] && rd_addr !== AW'(e_addr[c]))) rd_err++;
      if (col_valid !== e_cv[c] || (e_cv[c] && rd_addr !== AW'(e_addr[c]))) cv_err++;
      ce = c - RD_LAT;
      we = (ce >= 1) ? e_rd[ce] : 1'b0;
      if (wr_en !== we || (we && wr_addr !== AW'(e_addr[ce]))) wr_err++;
      if ((e_rd[c] || e_cv[c]) &&
          (x !== 8'(e_addr[c] % NX) || y !== 8'(e_addr[c] / NX))) xy_err++;
      if (busy !== (c <= done_c)) busy_err++;
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      if (wr_en === 1'b1) begin
        wr_cnt++;
        if (wr_addr !== AW'(wr_next)) order_err++;
        wr_next = (wr_next + 1) % DEPTH;
      end
      if (phase === 2'b10) coll++;
      if (col_valid === 1'b1 && collider_ready === 1'b1) acc_cnt++;
      if (abort_at != 0 && c == abort_at) begin
        check("pre_abort_phase_err", ph_err, 0);
        #2 rst = 1'b0;
        #1;
        check("rst_steps_done", steps_done, 0);
        check("rst_outputs", {rd_addr, rd_en, wr_addr, wr_en, x, y, col_valid,
                              phase, bank_sel, busy, done}, 0);
        for (int k = 0; k < 2; k++) begin
          @(posedge clk); #1;
          check("rst_no_wr_en", wr_en, 1'b0);
        end
        @(negedge clk) rst = 1'b1;
        start = 1'b0;
        exp_bank = 1'b0;
        return;
      end
    end
    start = 1'b0;
    last_coll = coll;
    check("phase_err", ph_err, 0);
    check("rd_err", rd_err, 0);
    check("wr_err", wr_err, 0);
    check("col_valid_err", cv_err, 0);
    check("xy_err", xy_err, 0);
    check("busy_err", busy_err, 0);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_at, done_c);
    check("wr_count", wr_cnt, nsteps * DEPTH);
    check("wr_order_err", order_err, 0);
    check("accepts", acc_cnt, nsteps * DEPTH);
    check("steps_done", steps_done, nsteps);
    exp_bank = exp_bank ^ nsteps[0];
    check("bank_sel", bank_sel, exp_bank);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_steps_done", steps_done, 0);
    check("reset_outputs", {rd_addr, rd_en, wr_addr, wr_en, x, y, col_valid,
                            phase, bank_sel, busy, done}, 0);
    @(negedge clk) rst = 1'b1;

    // start while en is low must be ignored
    @(posedge clk); #1;
    start = 1'b1; en = 1'b0; step = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; en = 1'b1;
    #1;
    check("start_en0_phase", phase, 2'b00);
    check("start_en0_busy", busy, 1'b0);

    run(0, 0, 0, 0, 1'b0);
    check("step0_done_cycle", done_at, 1);

    run(3, 0, 0, 0, 1'b0);
    check("step3_bank_final", bank_sel, 1'b1);

    run(1, 0, 0, 3000, 1'b0);

    run(1, 0, 0, 0, 1'b0);
    check("step1_done_5003", done_at, 5003);
    check("step1_bank", bank_sel, 1'b1);

    run(1, 0, 1, 0, 1'b0);
    check("toggle_collide_len", last_coll, 5000);

    run(1, 2, 0, 0, 1'b0);

    run($urandom_range(1, 2), 1, 2, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbm_step_scheduler.md
LBM_STEP_SCHEDULER -- requirements
Module: lbm_step_scheduler

Interface
REQ-001 SHALL have parameter NX, default 50, grid width in cells.
REQ-002 SHALL have parameter NY, default 50, grid height in cells; NX*NY equals `DEPTH.
REQ-003 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, global run enable; low stalls new issue.
REQ-007 SHALL have port start, input, 1, single-cycle run request.
REQ-008 SHALL have port step, input, 32, number of timesteps to run; sampled on accepted start.
REQ-009 SHALL have port collider_ready, input, 1, collider accepts a cell this cycle.
REQ-010 SHALL have port rd_addr, output, `ADDRESS_WIDTH, cell address presented to the current-bank RAMs.
REQ-011 SHALL have port rd_en, output, 1, streaming read issued this cycle.
REQ-012 SHALL have port wr_addr, output, `ADDRESS_WIDTH, streaming write address to the next-bank RAMs.
REQ-013 SHALL have port wr_en, output, 1, streaming write strobe.
REQ-014 SHALL have ports x and y, output, 8 each, coordinates of rd_addr (rd_addr = y*NX + x).
REQ-015 SHALL have port col_valid, output, 1, cell at rd_addr offered to the collider.
REQ-016 SHALL have port phase, output, 2: 00 idle, 01 stream, 10 collide, 11 swap/done.
REQ-017 SHALL have port bank_sel, output, 1, selects which of the c*/c*_n RAM sets is current.
REQ-018 SHALL have ports steps_done (output, 32, completed timesteps), busy (output, 1) and done (output, 1, one-cycle completion pulse).

Function
REQ-019 SHALL implement states IDLE, STREAM, COLLIDE, SWAP and DONE.
REQ-020 In IDLE, start=1 with en=1 SHALL latch step and clear steps_done; if step==0, the FSM SHALL go to DONE; otherwise it SHALL go to STREAM with cell=0, x=0, y=0.
REQ-021 start SHALL be ignored while busy=1 and while en=0.
REQ-022 In STREAM, each en=1 cycle SHALL assert rd_en with rd_addr=cell, then increment cell; x SHALL wrap NX-1 to 0 with y+1.
REQ-023 wr_en and wr_addr SHALL equal rd_en and rd_addr delayed exactly RD_LAT cycles; in-flight writes SHALL complete even if en falls.
REQ-024 After cell NX*NY-1 is issued, STREAM SHALL wait RD_LAT drain cycles, then enter COLLIDE with cell, x and y reset to 0.
REQ-025 In COLLIDE, col_valid SHALL equal en; cell SHALL advance only on col_valid & collider_ready.
REQ-026 Acceptance of cell NX*NY-1 SHALL move the FSM to SWAP.
REQ-027 SWAP SHALL last one cycle, toggle bank_sel and increment steps_done; it SHALL go to DONE if the new steps_done equals the latched step, else to STREAM.
REQ-028 DONE SHALL assert done for one cycle and return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 rd_en, wr_en and col_valid SHALL never be high simultaneously with a different phase's strobe; rd_en SHALL be 0 outside STREAM and col_valid SHALL be 0 outside COLLIDE.
REQ-031 The cell counter SHALL be `ADDRESS_WIDTH bits wide; steps_done SHALL wrap modulo 2^32.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, clear all counters and the delay pipeline, and drive every output to 0, including bank_sel.
REQ-033 Reset asserted mid-run SHALL abort without any further wr_en; the RAM contents left behind are undefined.

Verification
REQ-034 Reset, start with step=0 -> done pulses the cycle after start; wr_en is never high; steps_done=0; bank_sel=0.
REQ-035 step=1, collider_ready=1, en=1, start at edge 0 -> 2500 wr_en pulses with wr_addr 0..2499 in order; done is high in cycle 5003; bank_sel=1; steps_done=1.
REQ-036 step=1, collider_ready toggling every other cycle -> exactly 2500 accepted handshakes; the COLLIDE phase lasts 5000 cycles.
REQ-037 en low for 10 cycles at cell 1000 of STREAM -> rd_en=0 for those cycles, the one pending write completes, and issue resumes at cell 1000 with no gap or duplicate in wr_addr.
REQ-038 step=3 -> bank_sel toggles three times, ending at 1; steps_done=3; one done pulse.
REQ-039 rst low during COLLIDE -> all outputs 0 immediately; a new start with step=1 completes normally.
